// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state
// encoding, parity mode constants and the counter width helper.
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_CLEANUP    = 3'd5,
        ST_BREAK_WAIT = 3'd6
    } rx_state_t;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Width of a counter that must hold 0..n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Input synchroniser, per-bit window counter and 3-sample majority voter.
// The counter runs only while i_Enable is high and is held at 0 otherwise,
// so the receiver FSM controls where each bit window starts.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8073,
    parameter int SYNC_STAGES  = 2
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Rx_Serial,
    input  logic i_Enable,
    output logic o_Rx,
    output logic o_Bit_Val,
    output logic o_Bit_Decide,
    output logic o_Bit_End
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] C_S0  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] C_S1  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] C_DEC = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] C_END = CNT_W'(CLKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_s0;
    logic                   r_s1;
    logic                   w_rx;

    assign w_rx = r_sync[SYNC_STAGES-1];

    // Synchroniser chain; resets to the idle (high) line level
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_Rx_Serial};
        end
    end

    // Bit window counter: 0..CLKS_PER_BIT-1 while enabled, parked at 0 otherwise
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_cnt <= '0;
        end else if (!i_Enable || (r_cnt == C_END)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Capture the first two of the three mid-bit samples
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else begin
            if (r_cnt == C_S0) r_s0 <= w_rx;
            if (r_cnt == C_S1) r_s1 <= w_rx;
        end
    end

    // Third sample is the live value at the decision count
    assign o_Rx         = w_rx;
    assign o_Bit_Val    = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign o_Bit_Decide = i_Enable && (r_cnt == C_DEC);
    assign o_Bit_End    = i_Enable && (r_cnt == C_END);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity mode and stop-bit count
// are parameters. Reports parity/framing errors with each word and flags
// an all-zero frame as a break, then waits for the line to return high.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8073,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int                IDX_W     = cnt_width(DATA_BITS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

    rx_state_t             r_state;
    logic [IDX_W-1:0]      r_bit_idx;
    logic                  r_stop_idx;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_par_err;
    logic                  r_frm_err;
    logic                  r_all_zero;
    logic                  r_rx_dv;
    logic [DATA_BITS-1:0]  r_rx_byte;
    logic                  r_parity_err;
    logic                  r_frame_err;
    logic                  r_break;

    logic w_rx;
    logic w_bit_val;
    logic w_decide;
    logic w_end;
    logic w_run;
    logic w_par_exp;

    // Bit counter only runs while a frame is being timed
    assign w_run = (r_state == ST_START) || (r_state == ST_DATA) ||
                   (r_state == ST_PARITY) || (r_state == ST_STOP);

    // Even parity expects the XOR of the data; odd parity expects its inverse
    assign w_par_exp = (PARITY == PAR_EVEN) ? (^r_data) : ~(^r_data);

    uart_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_sampler (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_Rx_Serial  (i_Rx_Serial),
        .i_Enable     (w_run),
        .o_Rx         (w_rx),
        .o_Bit_Val    (w_bit_val),
        .o_Bit_Decide (w_decide),
        .o_Bit_End    (w_end)
    );

    // Receiver FSM with registered result, error and pulse outputs
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state      <= ST_IDLE;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_data       <= '0;
            r_par_err    <= 1'b0;
            r_frm_err    <= 1'b0;
            r_all_zero   <= 1'b0;
            r_rx_dv      <= 1'b0;
            r_rx_byte    <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break      <= 1'b0;
        end else begin
            r_rx_dv <= 1'b0;
            r_break <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx) r_state <= ST_START;
                end
                ST_START: begin
                    if (w_decide && w_bit_val) begin
                        r_state <= ST_IDLE;
                    end else if (w_end) begin
                        r_state    <= ST_DATA;
                        r_bit_idx  <= '0;
                        r_par_err  <= 1'b0;
                        r_frm_err  <= 1'b0;
                        r_all_zero <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_decide) begin
                        r_data[r_bit_idx] <= w_bit_val;
                        if (w_bit_val) r_all_zero <= 1'b0;
                    end
                    if (w_end) begin
                        if (r_bit_idx == LAST_IDX) begin
                            r_state    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            r_stop_idx <= 1'b0;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_decide) begin
                        if (w_bit_val != w_par_exp) r_par_err <= 1'b1;
                        if (w_bit_val) r_all_zero <= 1'b0;
                    end
                    if (w_end) begin
                        r_state    <= ST_STOP;
                        r_stop_idx <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (w_decide && (r_stop_idx == LAST_STOP)) begin
                        // Final stop bit: leave at mid-bit to gain resync margin
                        r_state      <= ST_CLEANUP;
                        r_rx_dv      <= 1'b1;
                        r_rx_byte    <= r_data;
                        r_parity_err <= r_par_err;
                        r_frame_err  <= r_frm_err | ~w_bit_val;
                        r_break      <= r_all_zero & ~w_bit_val;
                    end else begin
                        if (w_decide) begin
                            if (!w_bit_val) r_frm_err <= 1'b1;
                            if (w_bit_val) r_all_zero <= 1'b0;
                        end
                        if (w_end) r_stop_idx <= r_stop_idx + 1'b1;
                    end
                end
                ST_CLEANUP: begin
                    // r_break is high exactly during this cycle for a break frame
                    r_state <= r_break ? ST_BREAK_WAIT : ST_IDLE;
                end
                ST_BREAK_WAIT: begin
                    if (w_rx) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Rx_DV      = r_rx_dv;
    assign o_Rx_Byte    = r_rx_byte;
    assign o_Parity_Err = r_parity_err;
    assign o_Frame_Err  = r_frame_err;
    assign o_Break      = r_break;
    assign o_Busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three receivers (8N1, 8E1, 7O2) at
// 16 clocks per bit. Expected words are queued as each frame is driven and
// compared when the matching receiver pulses o_Rx_DV.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic rx_c = 1'b1;

    logic       a_dv, a_perr, a_ferr, a_brk, a_busy;
    logic [7:0] a_byte;
    logic       b_dv, b_perr, b_ferr, b_brk, b_busy;
    logic [7:0] b_byte;
    logic       c_dv, c_perr, c_ferr, c_brk, c_busy;
    logic [6:0] c_byte;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int n_cmp = 0;
    int n_err = 0;
    int dv_a = 0, dv_b = 0, dv_c = 0;
    int brk_a = 0, brk_b = 0, brk_c = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_a (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a),
        .o_Rx_DV(a_dv), .o_Rx_Byte(a_byte), .o_Parity_Err(a_perr),
        .o_Frame_Err(a_ferr), .o_Break(a_brk), .o_Busy(a_busy)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u_b (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b),
        .o_Rx_DV(b_dv), .o_Rx_Byte(b_byte), .o_Parity_Err(b_perr),
        .o_Frame_Err(b_ferr), .o_Break(b_brk), .o_Busy(b_busy)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .SYNC_STAGES(2)) u_c (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_c),
        .o_Rx_DV(c_dv), .o_Rx_Byte(c_byte), .o_Parity_Err(c_perr),
        .o_Frame_Err(c_ferr), .o_Break(c_brk), .o_Busy(c_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input int which, input logic v);
        case (which)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic push_exp(input int which, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        case (which)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    // Drive one bit window; an optional single-clock high spike lands on one vote sample
    task automatic drive_bit(input int which, input logic v, input bit spike);
        for (int cyc = 0; cyc < CPB; cyc++) begin
            set_line(which, (spike && cyc == 8) ? 1'b1 : v);
            @(negedge clk);
        end
    endtask

    // Drive a complete frame and queue the expected result
    task automatic send_frame(input int which, input int nbits, input logic [8:0] data,
                              input int par_mode, input bit flip_par, input int nstop,
                              input logic stop_val, input int spike_bit);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ data[i];
        if (par_mode == 1) p = ~p;
        if (flip_par) p = ~p;
        push_exp(which, data, (par_mode != 0) && flip_par, ~stop_val);
        drive_bit(which, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(which, data[i], i == spike_bit);
        if (par_mode != 0) drive_bit(which, p, 1'b0);
        for (int i = 0; i < nstop; i++) drive_bit(which, stop_val, 1'b0);
        set_line(which, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    // Scoreboard: compare each received word against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (a_brk) brk_a++;
        if (b_brk) brk_b++;
        if (c_brk) brk_c++;
        if (a_dv) begin
            dv_a++;
            $display("rx a: byte=%02h perr=%0d ferr=%0d brk=%0d", a_byte, a_perr, a_ferr, a_brk);
            if (q_a.size() == 0) check("a_unexpected_dv", 32'd1, 32'd0);
            else begin
                e = q_a.pop_front();
                check("a_byte", 32'(a_byte), 32'(e.data[7:0]));
                check("a_perr", 32'(a_perr), 32'(e.perr));
                check("a_ferr", 32'(a_ferr), 32'(e.ferr));
            end
        end
        if (b_dv) begin
            dv_b++;
            $display("rx b: byte=%02h perr=%0d ferr=%0d brk=%0d", b_byte, b_perr, b_ferr, b_brk);
            if (q_b.size() == 0) check("b_unexpected_dv", 32'd1, 32'd0);
            else begin
                e = q_b.pop_front();
                check("b_byte", 32'(b_byte), 32'(e.data[7:0]));
                check("b_perr", 32'(b_perr), 32'(e.perr));
                check("b_ferr", 32'(b_ferr), 32'(e.ferr));
            end
        end
        if (c_dv) begin
            dv_c++;
            $display("rx c: byte=%02h perr=%0d ferr=%0d brk=%0d", c_byte, c_perr, c_ferr, c_brk);
            if (q_c.size() == 0) check("c_unexpected_dv", 32'd1, 32'd0);
            else begin
                e = q_c.pop_front();
                check("c_byte", 32'(c_byte), 32'(e.data[6:0]));
                check("c_perr", 32'(c_perr), 32'(e.perr));
                check("c_ferr", 32'(c_ferr), 32'(e.ferr));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv_before;
        int pend;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dv",   32'(a_dv),   32'd0);
        check("rst_byte", 32'(a_byte), 32'd0);
        check("rst_perr", 32'(a_perr), 32'd0);
        check("rst_ferr", 32'(a_ferr), 32'd0);
        check("rst_brk",  32'(a_brk),  32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 clean frame
        send_frame(0, 8, 9'h0A5, 0, 1'b0, 1, 1'b1, -1);
        check("a5_busy_after", 32'(a_busy), 32'd0);

        // Even parity: wrong parity bit then correct one
        send_frame(1, 8, 9'h037, 2, 1'b1, 1, 1'b1, -1);
        send_frame(1, 8, 9'h037, 2, 1'b0, 1, 1'b1, -1);

        // Stop bit driven low: framing error but not a break
        send_frame(0, 8, 9'h055, 0, 1'b0, 1, 1'b0, -1);
        check("55_no_break", 32'(brk_a), 32'd0);
        repeat (CPB) @(negedge clk);

        // Short low glitch on idle line is rejected
        dv_before = dv_a;
        set_line(0, 1'b0);
        repeat (3) @(negedge clk);
        set_line(0, 1'b1);
        repeat (CPB) @(negedge clk);
        check("glitch_busy", 32'(a_busy), 32'd0);
        check("glitch_no_dv", 32'(dv_a), 32'(dv_before));

        // Single-clock spike inside data bit 3 of 0x00
        send_frame(0, 8, 9'h000, 0, 1'b0, 1, 1'b1, 3);

        // Line held low for 12 bit times: one word, one break, then silence
        push_exp(0, 9'h000, 1'b0, 1'b1);
        set_line(0, 1'b0);
        repeat (12 * CPB) @(negedge clk);
        check("break_count", 32'(brk_a), 32'd1);
        set_line(0, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        send_frame(0, 8, 9'h03C, 0, 1'b0, 1, 1'b1, -1);

        // Reset during data bit 4 abandons the frame (0x81 pattern, LSB first)
        dv_before = dv_a;
        drive_bit(0, 1'b0, 1'b0);
        drive_bit(0, 1'b1, 1'b0);
        drive_bit(0, 1'b0, 1'b0);
        drive_bit(0, 1'b0, 1'b0);
        drive_bit(0, 1'b0, 1'b0);
        repeat (CPB / 2) @(negedge clk);
        check("mid_busy", 32'(a_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mrst_byte", 32'(a_byte), 32'd0);
        check("mrst_busy", 32'(a_busy), 32'd0);
        check("mrst_dv",   32'(a_dv),   32'd0);
        check("mrst_ferr", 32'(a_ferr), 32'd0);
        repeat (3) @(negedge clk);
        set_line(0, 1'b1);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("mrst_no_dv", 32'(dv_a), 32'(dv_before));
        send_frame(0, 8, 9'h081, 0, 1'b0, 1, 1'b1, -1);

        // 7 data bits, odd parity, two stop bits
        send_frame(2, 7, 9'h07F, 1, 1'b0, 2, 1'b1, -1);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 400 && (q_a.size() + q_b.size() + q_c.size()) != 0; i++)
            @(negedge clk);
        pend = q_a.size() + q_b.size() + q_c.size();
        check("drain_pending", 32'(pend), 32'd0);
        check("a_dv_total", 32'(dv_a), 32'd6);
        check("b_dv_total", 32'(dv_b), 32'd2);
        check("c_dv_total", 32'(dv_c), 32'd1);
        check("a_brk_total", 32'(brk_a), 32'd1);
        check("bc_brk_total", 32'(brk_b + brk_c), 32'd0);
        check("end_busy", 32'({a_busy, b_busy, c_busy}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the next-generation serial input for the MIPS pipeline's memory-mapped UART peripheral. It supports configurable data width, parity mode and stop-bit count. It uses 3-sample majority voting per bit and reports parity, framing and break conditions alongside each received word. It has a single clock domain and drops into the existing UART slot in place of the fixed 8N1 receiver.

Parameters:
CLKS_PER_BIT, 8073, clocks per bit (77.5 MHz / 9600); must be >= 8
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits: 1 or 2
SYNC_STAGES, 2, input synchroniser depth; must be >= 2

Ports:
i_Clock  in  1  system clock; all logic on rising edge
i_Reset  in  1  asynchronous, active-high reset
i_Rx_Serial  in  1  raw serial line; idles high
o_Rx_DV  out  1  one-cycle pulse: frame complete; o_Rx_Byte and error flags are valid
o_Rx_Byte  out  DATA_BITS  received data, LSB first on the line; held until the next o_Rx_DV
o_Parity_Err  out  1  parity mismatch for the current frame; valid with o_Rx_DV; held until the next o_Rx_DV
o_Frame_Err  out  1  a stop bit sampled as 0; valid with o_Rx_DV; held until the next o_Rx_DV
o_Break  out  1  one-cycle pulse: break condition detected
o_Busy  out  1  high in every state except IDLE

Behaviour:
- Reset: asynchronous, active-high.
  - Synchroniser stages reset to 1.
  - State goes to IDLE; counters go to 0.
  - o_Rx_DV, o_Break, o_Parity_Err and o_Frame_Err reset to 0.
  - o_Rx_Byte resets to 0; o_Busy resets to 0.
  - Reset asserted mid-frame abandons the frame with no o_Rx_DV.
- Synchroniser: i_Rx_Serial passes through SYNC_STAGES flops; all logic below uses the synchronised value (rx).
- Bit timing:
  - Bit counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 per bit window, then wraps to 0.
  - HALF = (CLKS_PER_BIT-1)/2.
  - rx is sampled at counts HALF-1, HALF and HALF+1. The bit value is the majority of the three, decided at count HALF+1.
- States: IDLE, START, DATA, PARITY, STOP, CLEANUP, BREAK_WAIT.
- IDLE: rx == 0 moves to START with the counter at 0. Otherwise the state stays IDLE.
- START:
  - Vote = 1: glitch; return to IDLE at the decision cycle, with no outputs.
  - Vote = 0: continue to the end of the window, then enter DATA with bit index 0.
- DATA:
  - Each vote is shifted into data[index].
  - At the end of the window, index increments.
  - After index DATA_BITS-1, go to PARITY if PARITY != 0, else to STOP.
- PARITY:
  - Expected bit is XOR(data) for even parity, ~XOR(data) for odd parity.
  - A mismatch sets the internal parity-error flag.
  - Go to STOP at the end of the window.
- STOP:
  - Each stop bit is voted; a 0 sets the internal frame-error flag.
  - A non-final stop bit runs its full window.
  - The final stop bit exits at its decision cycle (HALF+1), giving a half-bit resync margin, and goes to CLEANUP.
- CLEANUP (one cycle):
  - o_Rx_DV = 1; o_Rx_Byte, o_Parity_Err and o_Frame_Err update in this same cycle.
  - If every data bit, the parity bit (if present) and all stop bits voted 0: pulse o_Break in this cycle and go to BREAK_WAIT.
  - Otherwise go to IDLE.
- BREAK_WAIT: stay until rx == 1, then go to IDLE. No new start bit is detected while the line is held low.
- Back-to-back frames: a start edge is accepted in the first IDLE cycle after CLEANUP.
- Output width: o_Rx_Byte width is exactly DATA_BITS, with no padding.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams.
  - Parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN.
  - Width function for the bit counter.
- One natural sub-module: uart_bit_sampler. It contains the synchroniser, bit counter and majority voter, and outputs rx, bit_val, bit_decide and bit_end.
- The FSM stays in uart_rx_cfg.

Test Plan:
- All scenarios use CLKS_PER_BIT = 16.
- 8N1, send 0xA5 -> exactly one o_Rx_DV pulse; o_Rx_Byte = 0xA5; both error flags 0; o_Busy low after CLEANUP.
- PARITY = 2, send 0x37 with parity bit 0 (correct bit is 1) -> o_Rx_DV; o_Rx_Byte = 0x37; o_Parity_Err = 1. Next frame 0x37 with parity bit 1 -> o_Parity_Err = 0.
- 8N1, send 0x55 with the stop bit driven 0 -> o_Rx_Byte = 0x55; o_Frame_Err = 1; o_Break = 0.
- 3-clock low glitch on an idle line -> no o_Rx_DV; o_Busy returns to 0 within 16 clocks. A 1-clock high spike mid data bit of 0x00 still gives o_Rx_Byte = 0x00.
- Line held low for 12 bit times -> one o_Rx_DV with 0x00 and o_Frame_Err = 1; one o_Break pulse; no further o_Rx_DV. Line released, then 0x3C sent -> o_Rx_Byte = 0x3C with no errors.
- i_Reset pulsed during data bit 4 -> all outputs 0 immediately; no o_Rx_DV. A following 0x81 frame is received correctly. Variant DATA_BITS = 7, STOP_BITS = 2, PARITY = 1 sending 0x7F -> o_Rx_Byte = 7'h7F with no errors.
